// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and deglitches the device-driven lines, deframes
// 11-bit frames and queues good bytes in a small FIFO read with a rd/valid handshake.
module ps2_receiver #(
    parameter int unsigned FREQ_MHZ      = 50,
    parameter int unsigned FILTER_CYCLES = 8,
    parameter int unsigned TIMEOUT_US    = 1000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset_button,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd,
    input  logic       err_clr,
    output logic       valid,
    output logic [7:0] rx_data,
    output logic       frame_error,
    output logic       overflow
);

    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_US * FREQ_MHZ;
    localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned AW             = $clog2(FIFO_DEPTH);
    localparam logic [7:0]    FILT_MAX     = 8'(FILTER_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_f_q, fall_q;
    logic [7:0]    filt_cnt_q;
    state_e        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          frame_error_q, overflow_q;

    logic timeout, stop_ok, push, err_set;
    logic empty, full, pop, do_write, ovf_set;

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // The filtered clock only follows a level that has held for FILTER_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            clk_f_q    <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_s2_q == clk_f_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_MAX) begin
                clk_f_q    <= clk_s2_q;
                filt_cnt_q <= '0;
                fall_q     <= clk_f_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        timeout = (state_q != StIdle) && !fall_q && (timer_q == TIMEOUT_MAX);
        stop_ok = dat_s2_q && (^{shift_q, parity_q});
        push    = fall_q && (state_q == StStop) && stop_ok;
        err_set = timeout || (fall_q && (state_q == StStop) && !stop_ok);
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            timer_q   <= '0;
        end else begin
            if (state_q == StIdle || fall_q) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            if (timeout) begin
                state_q <= StIdle;
            end else if (fall_q) begin
                case (state_q)
                    StIdle: begin
                        if (!dat_s2_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q[bit_cnt_q] <= dat_s2_q;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_q <= dat_s2_q;
                        state_q  <= StStop;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    // One extra pointer bit separates full from empty when the index bits match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = rd && !empty;
        do_write = push && (!full || pop);
        ovf_set  = push && full && !pop;
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_write) begin
                mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_button) begin
        if (!reset_button) begin
            frame_error_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (err_set) begin
                frame_error_q <= 1'b1;
            end else if (err_clr) begin
                frame_error_q <= 1'b0;
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (err_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign valid       = !empty;
    assign rx_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: a PS/2 device model with a 40-cycle bit period and a
// shortened 100-cycle timeout, checked against hand-computed bytes and flags.
module tb_ps2_receiver;

    logic       clk = 1'b0;
    logic       reset_button = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd = 1'b0;
    logic       err_clr = 1'b0;
    logic       valid;
    logic [7:0] rx_data;
    logic       frame_error;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    ps2_receiver #(
        .FREQ_MHZ      (50),
        .FILTER_CYCLES (8),
        .TIMEOUT_US    (2),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .reset_button (reset_button),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rd           (rd),
        .err_clr      (err_clr),
        .valid        (valid),
        .rx_data      (rx_data),
        .frame_error  (frame_error),
        .overflow     (overflow)
    );

    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // mode 0 plain, 1 short clock glitch in the high phase, 2 rd on the push edge,
    // 3 check that valid rises exactly on the push edge
    task automatic ps2_bit(input logic b, input int mode);
        ps2_data = b;
        if (mode == 1) begin
            repeat (3) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            repeat (10) @(negedge clk);
        end
        ps2_clk = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mode == 2) rd = (i == 11);
            if (mode == 3 && i == 11) begin
                checks++;
                if (valid !== 1'b0) begin
                    errors++;
                    $display("FAIL latency_early: valid got %b required 0", valid);
                end
            end
            if (mode == 3 && i == 12) begin
                checks++;
                if (valid !== 1'b1) begin
                    errors++;
                    $display("FAIL latency_push: valid got %b required 1", valid);
                end
            end
        end
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_ok, input int nbits,
                              input int bit_mode, input int stop_mode);
        logic [10:0] fr;
        fr = {1'b1, (par_ok ? ~^d : ^d), d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(fr[i], (i == 10) ? stop_mode : bit_mode);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks += 4;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error: got %b required 0", frame_error); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        reset_button = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(8'h1C, 1'b1, 11, 0, 3);
        checks += 3;
        if (valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b required 1", valid); end
        if (rx_data !== 8'h1C) begin errors++; $display("FAIL basic_data: got %h required 1c", rx_data); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b required 0", frame_error); end
        pulse_rd();
        checks += 2;
        if (valid !== 1'b0) begin errors++; $display("FAIL basic_pop: valid got %b required 0", valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b required 0", overflow); end
        pulse_rd();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL rd_empty: valid got %b required 0", valid); end
    endtask

    task automatic test_parity();
        send_frame(8'hF0, 1'b0, 11, 0, 0);
        checks += 2;
        if (valid !== 1'b0) begin errors++; $display("FAIL parity_nopush: valid got %b required 0", valid); end
        if (frame_error !== 1'b1) begin errors++; $display("FAIL parity_ferr: got %b required 1", frame_error); end
        pulse_err_clr();
        checks++;
        if (frame_error !== 1'b0) begin errors++; $display("FAIL parity_clr: got %b required 0", frame_error); end
        send_frame(8'hF0, 1'b1, 11, 0, 0);
        checks += 3;
        if (valid !== 1'b1) begin errors++; $display("FAIL parity_good_valid: got %b required 1", valid); end
        if (rx_data !== 8'hF0) begin errors++; $display("FAIL parity_good_data: got %h required f0", rx_data); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL parity_good_ferr: got %b required 0", frame_error); end
        pulse_rd();
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 11, 0, 0);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL ovf_ferr: got %b required 0", frame_error); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++;
            if (valid !== 1'b1 || rx_data !== exp)
                begin errors++; $display("FAIL ovf_read%0d: got valid %b data %h required 1 %h", i, valid, rx_data, exp); end
            pulse_rd();
        end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: valid got %b required 0", valid); end
        pulse_err_clr();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b required 0", overflow); end
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 11, 0, 0);
        send_frame(8'h05, 1'b1, 11, 0, 2);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL full_rd_ovf: got %b required 0", overflow); end
        for (int i = 2; i <= 5; i++) begin
            exp = 8'(i);
            checks++;
            if (valid !== 1'b1 || rx_data !== exp)
                begin errors++; $display("FAIL full_rd_read%0d: got valid %b data %h required 1 %h", i, valid, rx_data, exp); end
            pulse_rd();
        end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL full_rd_drained: valid got %b required 0", valid); end
    endtask

    task automatic test_timeout();
        send_frame(8'hA5, 1'b1, 4, 0, 0);
        repeat (55) @(negedge clk);
        checks++;
        if (frame_error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b required 0", frame_error); end
        repeat (40) @(negedge clk);
        checks += 2;
        if (frame_error !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b required 1", frame_error); end
        if (valid !== 1'b0) begin errors++; $display("FAIL timeout_nopush: valid got %b required 0", valid); end
        pulse_err_clr();
        send_frame(8'h1C, 1'b1, 11, 0, 0);
        checks += 2;
        if (rx_data !== 8'h1C || valid !== 1'b1) begin errors++; $display("FAIL timeout_next: got valid %b data %h required 1 1c", valid, rx_data); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL timeout_next_ferr: got %b required 0", frame_error); end
        pulse_rd();
    endtask

    task automatic test_glitch();
        send_frame(8'h5A, 1'b1, 11, 1, 1);
        checks += 2;
        if (rx_data !== 8'h5A || valid !== 1'b1) begin errors++; $display("FAIL glitch_data: got valid %b data %h required 1 5a", valid, rx_data); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b required 0", frame_error); end
        pulse_rd();
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        repeat (30) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        checks += 2;
        if (frame_error !== 1'b0) begin errors++; $display("FAIL idle_spur_ferr: got %b required 0", frame_error); end
        if (valid !== 1'b0) begin errors++; $display("FAIL idle_spur_valid: got %b required 0", valid); end
        send_frame(8'h1C, 1'b1, 11, 0, 0);
        checks++;
        if (rx_data !== 8'h1C || valid !== 1'b1) begin errors++; $display("FAIL idle_spur_next: got valid %b data %h required 1 1c", valid, rx_data); end
        pulse_rd();
    endtask

    task automatic test_mid_reset();
        send_frame(8'h33, 1'b1, 11, 0, 0);
        send_frame(8'hF0, 1'b0, 11, 0, 0);
        send_frame(8'h29, 1'b1, 6, 0, 0);
        reset_button = 1'b0;
        repeat (2) @(negedge clk);
        checks += 3;
        if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", valid); end
        if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h required 00", rx_data); end
        if (frame_error !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b required 00", frame_error, overflow); end
        ps2_data     = 1'b1;
        ps2_clk      = 1'b1;
        reset_button = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h29, 1'b1, 11, 0, 0);
        checks += 2;
        if (rx_data !== 8'h29 || valid !== 1'b1) begin errors++; $display("FAIL midrst_next: got valid %b data %h required 1 29", valid, rx_data); end
        if (frame_error !== 1'b0) begin errors++; $display("FAIL midrst_next_ferr: got %b required 0", frame_error); end
        pulse_rd();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_overflow();
        test_timeout();
        test_glitch();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
